clk_div_bank: RTL and testbench
===============================

CLK_DIV_BANK -- requirements
Module: clk_div_bank

Interface
REQ-001 Parameter NCH, default 4, number of output channels (1..16).
REQ-002 Parameter DIV_W, default 8, divider width.
REQ-003 Parameter LOCK_FILT, default 16, consecutive synced lock samples required before release.
REQ-004 Parameter DEF_DIV, default 4, divider value loaded at reset.
REQ-005 Port clk  in  1  single system clock (PLL output domain); the block SHALL have one clock and a synchronous, active-low reset.
REQ-006 Port resetn  in  1  synchronous active-low reset.
REQ-007 Port pll_lock  in  1  PLL LOCK, asynchronous to clk.
REQ-008 Ports cfg_valid in 1, cfg_ready out 1, cfg_ch in $clog2(NCH) (min 1), cfg_div in DIV_W: divider update handshake.
REQ-009 Port ce  out  NCH  one-cycle clock-enable pulse per channel period.
REQ-010 Port clk_out  out  NCH  divided square wave per channel, registered.
REQ-011 Port rst_out_n  out  NCH  per-channel synchronous reset for downstream logic.
REQ-012 Port locked  out  1  high only in RUN.
REQ-013 Port lock_loss_cnt  out  8  saturating count of lock losses.

Function
REQ-014 pll_lock SHALL pass through a 2-flop synchronizer; all decisions SHALL use the second-flop output (lk).
REQ-015 FSM states SHALL be WAIT_LOCK, FILTER, RELEASE, RUN.
REQ-016 WAIT_LOCK -> FILTER when lk=1; filter counter cleared.
REQ-017 FILTER: the counter SHALL increment per lk=1 cycle, return to WAIT_LOCK with counter cleared on lk=0, and go to RELEASE after LOCK_FILT consecutive lk=1 cycles.
REQ-018 RELEASE SHALL last NCH cycles; rst_out_n[i] SHALL rise at RELEASE cycle i (channel 0 first) and stay high; RUN follows.
REQ-019 lk=0 in FILTER-exit, RELEASE or RUN SHALL, on that edge, clear all rst_out_n, ce, clk_out and locked, zero all channel counters, go to WAIT_LOCK, and increment lock_loss_cnt (saturating at 255) if leaving RELEASE or RUN.
REQ-020 Per channel with divider D: counter SHALL run 0..D-1 only in RUN, starting at 0 on the first RUN cycle (all channels phase-aligned).
REQ-021 ce[i] SHALL be high in the cycle counter==D-1; clk_out[i] SHALL be high while counter < D>>1.
REQ-022 D=0 and D=1 SHALL both behave as D=1: ce[i] constantly high in RUN, clk_out[i] low.
REQ-023 Each channel SHALL hold one pending update slot; cfg_ready = ~pending[cfg_ch] (combinational on cfg_ch).
REQ-024 A transfer (cfg_valid & cfg_ready) SHALL load pending[cfg_ch] with cfg_div; cfg_ch >= NCH SHALL be accepted and discarded.
REQ-025 A pending value SHALL apply at the channel's wrap (counter==D-1), or on the next edge if the FSM is not in RUN; pending clears on the same edge; no ce or clk_out glitch is permitted.
REQ-026 Simultaneous apply and new transfer to one channel cannot occur (cfg_ready low); a transfer in the same cycle as lock loss SHALL still be captured.

Reset
REQ-027 On resetn=0 at an edge: state WAIT_LOCK; sync flops, filter counter, channel counters, pending and lock_loss_cnt 0; dividers DEF_DIV; ce, clk_out, rst_out_n, locked 0; cfg_ready 1.
REQ-028 Reset SHALL override all other events, including mid-RELEASE and mid-update.

Structure
REQ-029 Package clk_div_pkg SHALL hold the FSM state enum and the LOCK_FILT counter-width constant/function.
REQ-030 Sub-module clk_div_chan (counter, divider register, pending slot, ce/clk_out registers) SHALL be instantiated NCH times; FSM and synchronizer stay in clk_div_bank.

Verification (NCH=4, DIV_W=8, LOCK_FILT=16, DEF_DIV=4)
REQ-031 pll_lock 0->1 held -> rst_out_n 0001,0011,0111,1111 on successive cycles, locked 1 after 2+16+4 edges, ce period 4, clk_out 2 high/2 low.
REQ-032 pll_lock low for 3 cycles at filter count 10 -> return to WAIT_LOCK, full 16-sample filter rerun, lock_loss_cnt stays 0.
REQ-033 In RUN, write ch1 div=10 at counter 1 -> ce[1] pulses at old period once more, then period 10; cfg_ready low for ch1 until wrap; ch2 write in between accepted.
REQ-034 Write ch2 div=1, then div=0 -> ce[2] constant 1, clk_out[2] 0 in both cases.
REQ-035 pll_lock drop in RUN -> within 3 edges all rst_out_n/ce/clk_out/locked 0, lock_loss_cnt 1; 300 lock cycles -> count saturates at 255.
REQ-036 resetn low 1 cycle mid-RUN with pending ch3 update -> all reset values next edge, ch3 divider back to 4, pending cleared.

Source files
------------

// File: rtl/clk_div_pkg.sv
// Shared types and sizing helpers for the lock-gated clock divider bank.
package clk_div_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    FILTER    = 2'd1,
    RELEASE   = 2'd2,
    RUN       = 2'd3
  } lock_state_e;

  // The filter counter only has to reach lock_filt-2: the sample that leaves
  // WAIT_LOCK is already the first of the lock_filt consecutive samples.
  function automatic int filt_cnt_w(input int lock_filt);
    return (lock_filt < 2) ? 1 : $clog2(lock_filt);
  endfunction

  function automatic int ch_idx_w(input int nch);
    return (nch < 2) ? 1 : $clog2(nch);
  endfunction

endpackage

// File: rtl/clk_div_bank_if.sv
// Divider-update handshake between a configuration master and the divider bank.
interface clk_div_bank_if
  import clk_div_pkg::*;
#(
  parameter int NCH   = 4,
  parameter int DIV_W = 8
) ();

  localparam int CH_W = ch_idx_w(NCH);

  logic             cfg_valid;
  logic             cfg_ready;
  logic [CH_W-1:0]  cfg_ch;
  logic [DIV_W-1:0] cfg_div;

  modport master (
    output cfg_valid,
    output cfg_ch,
    output cfg_div,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_ch,
    input  cfg_div,
    output cfg_ready
  );

endinterface

// File: rtl/clk_div_chan.sv
// One divider channel: phase counter, active divider, single pending update slot
// and registered ce / clk_out outputs.
module clk_div_chan #(
  parameter int DIV_W   = 8,
  parameter int DEF_DIV = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             run,
  input  logic             run_next,
  input  logic             wr_en,
  input  logic [DIV_W-1:0] wr_div,
  output logic             pending,
  output logic             ce,
  output logic             clk_out
);

  logic [DIV_W-1:0] div_reg;
  logic [DIV_W-1:0] div_next;
  logic [DIV_W-1:0] pend_div_reg;
  logic [DIV_W-1:0] pend_div_next;
  logic [DIV_W-1:0] cnt_reg;
  logic [DIV_W-1:0] cnt_next;
  logic [DIV_W-1:0] div_eff;
  logic [DIV_W-1:0] div_eff_next;
  logic             pending_reg;
  logic             pending_next;
  logic             ce_reg;
  logic             ce_next;
  logic             clk_out_reg;
  logic             clk_out_next;
  logic             at_wrap;
  logic             apply;

  // Dividers of 0 and 1 both mean "every cycle".
  function automatic logic [DIV_W-1:0] eff_div(input logic [DIV_W-1:0] d);
    return (d <= DIV_W'(1)) ? DIV_W'(1) : d;
  endfunction

  always_comb begin
    div_eff       = eff_div(div_reg);
    at_wrap       = run && (cnt_reg == div_eff - DIV_W'(1));
    // Swapping only at the wrap keeps the running period intact, so no short ce or clk_out phase.
    apply         = pending_reg && (!run || at_wrap);
    div_next      = apply ? pend_div_reg : div_reg;
    pending_next  = pending_reg;
    pend_div_next = pend_div_reg;
    if (wr_en) begin
      pending_next  = 1'b1;
      pend_div_next = wr_div;
    end else if (apply) begin
      pending_next  = 1'b0;
    end
    div_eff_next  = eff_div(div_next);
    if (!run_next || !run || at_wrap) begin
      cnt_next = '0;
    end else begin
      cnt_next = cnt_reg + DIV_W'(1);
    end
    ce_next       = run_next && (cnt_next == div_eff_next - DIV_W'(1));
    clk_out_next  = run_next && (cnt_next < (div_eff_next >> 1));
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      div_reg      <= DIV_W'(DEF_DIV);
      pend_div_reg <= '0;
      pending_reg  <= 1'b0;
      cnt_reg      <= '0;
      ce_reg       <= 1'b0;
      clk_out_reg  <= 1'b0;
    end else begin
      div_reg      <= div_next;
      pend_div_reg <= pend_div_next;
      pending_reg  <= pending_next;
      cnt_reg      <= cnt_next;
      ce_reg       <= ce_next;
      clk_out_reg  <= clk_out_next;
    end
  end

  assign pending = pending_reg;
  assign ce      = ce_reg;
  assign clk_out = clk_out_reg;

endmodule

// File: rtl/clk_div_bank.sv
// Lock-gated bank of NCH clock dividers: filters PLL lock, releases channel
// resets one by one, then runs all channels phase-aligned.
module clk_div_bank
  import clk_div_pkg::*;
#(
  parameter int NCH       = 4,
  parameter int DIV_W     = 8,
  parameter int LOCK_FILT = 16,
  parameter int DEF_DIV   = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             pll_lock,
  clk_div_bank_if.slave    cfg,
  output logic [NCH-1:0]   ce,
  output logic [NCH-1:0]   clk_out,
  output logic [NCH-1:0]   rst_out_n,
  output logic             locked,
  output logic [7:0]       lock_loss_cnt
);

  localparam int CH_W = ch_idx_w(NCH);
  localparam int FW   = filt_cnt_w(LOCK_FILT);
  localparam logic [FW-1:0]   FILT_LAST = FW'((LOCK_FILT >= 2) ? (LOCK_FILT - 2) : 0);
  localparam logic [CH_W-1:0] REL_LAST  = CH_W'(NCH - 1);

  lock_state_e     state_reg;
  lock_state_e     state_next;
  logic [FW-1:0]   filt_cnt_reg;
  logic [FW-1:0]   filt_cnt_next;
  logic [CH_W-1:0] rel_cnt_reg;
  logic [CH_W-1:0] rel_cnt_next;
  logic [7:0]      loss_cnt_reg;
  logic            loss_inc;
  logic            sync1_reg;
  logic            lk_reg;
  logic            locked_reg;
  logic [NCH-1:0]  rst_out_n_reg;
  logic [NCH-1:0]  rst_out_n_next;
  logic            run_cur;
  logic            run_next;
  logic [NCH-1:0]  pending_vec;
  logic [NCH-1:0]  ch_sel;
  logic [NCH-1:0]  wr_en;
  logic            cfg_rdy;

  // pll_lock is asynchronous to clk; only lk_reg is used downstream.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      sync1_reg <= 1'b0;
      lk_reg    <= 1'b0;
    end else begin
      sync1_reg <= pll_lock;
      lk_reg    <= sync1_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_reg     <= WAIT_LOCK;
      filt_cnt_reg  <= '0;
      rel_cnt_reg   <= '0;
      loss_cnt_reg  <= '0;
      locked_reg    <= 1'b0;
      rst_out_n_reg <= '0;
    end else begin
      state_reg     <= state_next;
      filt_cnt_reg  <= filt_cnt_next;
      rel_cnt_reg   <= rel_cnt_next;
      locked_reg    <= run_next;
      rst_out_n_reg <= rst_out_n_next;
      if (loss_inc && (loss_cnt_reg != 8'hFF)) begin
        loss_cnt_reg <= loss_cnt_reg + 8'd1;
      end
    end
  end

  always_comb begin
    state_next    = state_reg;
    filt_cnt_next = filt_cnt_reg;
    rel_cnt_next  = rel_cnt_reg;
    loss_inc      = 1'b0;
    case (state_reg)
      WAIT_LOCK: begin
        filt_cnt_next = '0;
        rel_cnt_next  = '0;
        if (lk_reg) begin
          state_next = FILTER;
        end
      end
      FILTER: begin
        if (!lk_reg) begin
          state_next    = WAIT_LOCK;
          filt_cnt_next = '0;
        end else if (filt_cnt_reg == FILT_LAST) begin
          state_next    = RELEASE;
          filt_cnt_next = '0;
          rel_cnt_next  = '0;
        end else begin
          filt_cnt_next = filt_cnt_reg + FW'(1);
        end
      end
      RELEASE: begin
        if (!lk_reg) begin
          state_next   = WAIT_LOCK;
          rel_cnt_next = '0;
          loss_inc     = 1'b1;
        end else if (rel_cnt_reg == REL_LAST) begin
          state_next   = RUN;
        end else begin
          rel_cnt_next = rel_cnt_reg + CH_W'(1);
        end
      end
      RUN: begin
        if (!lk_reg) begin
          state_next   = WAIT_LOCK;
          rel_cnt_next = '0;
          loss_inc     = 1'b1;
        end
      end
      default: begin
        state_next = WAIT_LOCK;
      end
    endcase
  end

  assign run_cur  = (state_reg == RUN);
  assign run_next = (state_next == RUN);

  // Out-of-range channel numbers select nothing, so they see ready and are dropped.
  assign cfg_rdy       = ~|(pending_vec & ch_sel);
  assign cfg.cfg_ready = cfg_rdy;

  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    assign ch_sel[gi]         = (cfg.cfg_ch == CH_W'(gi));
    assign wr_en[gi]          = cfg.cfg_valid & cfg_rdy & ch_sel[gi];
    assign rst_out_n_next[gi] = run_next ||
                                ((state_next == RELEASE) && (rel_cnt_next >= CH_W'(gi)));

    clk_div_chan #(
      .DIV_W   (DIV_W),
      .DEF_DIV (DEF_DIV)
    ) u_chan (
      .clk      (clk),
      .resetn   (resetn),
      .run      (run_cur),
      .run_next (run_next),
      .wr_en    (wr_en[gi]),
      .wr_div   (cfg.cfg_div),
      .pending  (pending_vec[gi]),
      .ce       (ce[gi]),
      .clk_out  (clk_out[gi])
    );
  end

  assign rst_out_n     = rst_out_n_reg;
  assign locked        = locked_reg;
  assign lock_loss_cnt = loss_cnt_reg;

endmodule

// File: tb/tb_clk_div_bank.sv
// Scoreboard bench for clk_div_bank: the stimulus pushes the hand-derived
// expected outputs for each cycle, a negedge monitor pops and compares them.
module tb_clk_div_bank;

  logic       clk = 1'b0;
  logic       resetn;
  logic       pll_lock;
  logic [3:0] ce;
  logic [3:0] clk_out;
  logic [3:0] rst_out_n;
  logic       locked;
  logic [7:0] lock_loss_cnt;

  clk_div_bank_if #(.NCH(4), .DIV_W(8)) cfg_if ();

  clk_div_bank #(
    .NCH       (4),
    .DIV_W     (8),
    .LOCK_FILT (16),
    .DEF_DIV   (4)
  ) dut (
    .clk           (clk),
    .resetn        (resetn),
    .pll_lock      (pll_lock),
    .cfg           (cfg_if),
    .ce            (ce),
    .clk_out       (clk_out),
    .rst_out_n     (rst_out_n),
    .locked        (locked),
    .lock_loss_cnt (lock_loss_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // val = {ce, clk_out, rst_out_n, locked, lock_loss_cnt, cfg_ready}
  typedef struct {
    int          cyc;
    string       tag;
    logic [21:0] val;
  } exp_t;

  exp_t        exp_q[$];
  int          vec_cnt  = 0;
  int          miss_cnt = 0;
  exp_t        mon_e;
  logic [21:0] mon_act;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input string tag, input logic [3:0] e_ce, input logic [3:0] e_clk,
                      input logic [3:0] e_rst, input logic e_lkd, input logic [7:0] e_loss,
                      input logic e_rdy);
    exp_t x;
    x.cyc = cyc;
    x.tag = tag;
    x.val = {e_ce, e_clk, e_rst, e_lkd, e_loss, e_rdy};
    exp_q.push_back(x);
  endtask

  // {ce, clk_out} for RUN cycle k of a channel whose divider is d
  function automatic logic [1:0] pat(input int k, input int d);
    int m;
    m = k % d;
    return {(m == d - 1), (m < d / 2)};
  endfunction

  task automatic push_run4(input string tag, input int k, input logic rdy);
    logic [1:0] p;
    p = pat(k, 4);
    push(tag, {4{p[1]}}, {4{p[0]}}, 4'hF, 1'b1, 8'd0, rdy);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      while (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
        mon_e = exp_q.pop_front();
        vec_cnt++;
        miss_cnt++;
        $display("FAIL %s cyc %0d: expectation was never sampled", mon_e.tag, mon_e.cyc);
      end
      if (exp_q.size() != 0 && exp_q[0].cyc == cyc) begin
        mon_e   = exp_q.pop_front();
        mon_act = {ce, clk_out, rst_out_n, locked, lock_loss_cnt, cfg_if.cfg_ready};
        vec_cnt++;
        if (mon_act !== mon_e.val) begin
          miss_cnt++;
          $display("FAIL %s cyc %0d: got ce=%b clk_out=%b rst_out_n=%b locked=%b loss=%0d ready=%b, expected ce=%b clk_out=%b rst_out_n=%b locked=%b loss=%0d ready=%b",
                   mon_e.tag, cyc, mon_act[21:18], mon_act[17:14], mon_act[13:10], mon_act[9],
                   mon_act[8:1], mon_act[0], mon_e.val[21:18], mon_e.val[17:14],
                   mon_e.val[13:10], mon_e.val[9], mon_e.val[8:1], mon_e.val[0]);
        end else begin
          $display("vec %s cyc %0d ok: ce=%b clk_out=%b rst_out_n=%b locked=%b loss=%0d ready=%b",
                   mon_e.tag, cyc, ce, clk_out, rst_out_n, locked, lock_loss_cnt,
                   cfg_if.cfg_ready);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached at cyc %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0] p0, p1, p2;
    logic       rdy;

    resetn             = 1'b0;
    pll_lock           = 1'b0;
    cfg_if.cfg_valid   = 1'b0;
    cfg_if.cfg_ch      = 2'd0;
    cfg_if.cfg_div     = 8'd0;

    tick(); tick();
    push("reset", 4'h0, 4'h0, 4'h0, 1'b0, 8'd0, 1'b1);
    tick();
    push("reset", 4'h0, 4'h0, 4'h0, 1'b0, 8'd0, 1'b1);

    // Lock rises, then glitches low for 3 cycles at filter count 10.
    resetn   = 1'b1;
    pll_lock = 1'b1;
    for (int n = 1; n <= 13; n++) begin
      tick();
      push("filter", 4'h0, 4'h0, 4'h0, 1'b0, 8'd0, 1'b1);
    end
    pll_lock = 1'b0;
    repeat (3) begin
      tick();
      push("lock_glitch", 4'h0, 4'h0, 4'h0, 1'b0, 8'd0, 1'b1);
    end

    // Full rerun: 2 sync + 16 filter edges, then 4 release cycles.
    pll_lock = 1'b1;
    for (int n = 1; n <= 17; n++) begin
      tick();
      push("refilter", 4'h0, 4'h0, 4'h0, 1'b0, 8'd0, 1'b1);
    end
    for (int n = 0; n < 4; n++) begin
      tick();
      push("release", 4'h0, 4'h0, 4'((1 << (n + 1)) - 1), 1'b0, 8'd0, 1'b1);
    end
    for (int k = 0; k <= 8; k++) begin
      tick();
      push_run4("run_div4", k, 1'b1);
    end

    // Divider updates: ch1 <- 10 at counter 1, ch2 <- 1 in between, later ch2 <- 0,
    // then ch3 <- 7 left pending when reset is pulsed.
    for (int k = 9; k <= 37; k++) begin
      tick();
      rdy = 1'b1;
      cfg_if.cfg_valid = 1'b0;
      case (k)
        9:       begin cfg_if.cfg_valid = 1'b1; cfg_if.cfg_ch = 2'd1; cfg_if.cfg_div = 8'd10; end
        10:      begin cfg_if.cfg_valid = 1'b1; cfg_if.cfg_ch = 2'd2; cfg_if.cfg_div = 8'd1;  end
        11:      begin cfg_if.cfg_ch = 2'd1; rdy = 1'b0; end
        12, 13:  begin cfg_if.cfg_ch = 2'd1; end
        14:      begin cfg_if.cfg_valid = 1'b1; cfg_if.cfg_ch = 2'd2; cfg_if.cfg_div = 8'd0;  end
        15:      begin cfg_if.cfg_ch = 2'd2; rdy = 1'b0; end
        36:      begin cfg_if.cfg_valid = 1'b1; cfg_if.cfg_ch = 2'd3; cfg_if.cfg_div = 8'd7;  end
        37:      begin cfg_if.cfg_ch = 2'd3; rdy = 1'b0; resetn = 1'b0; end
        default: begin cfg_if.cfg_ch = 2'd2; end
      endcase
      if (k < 12) begin
        push_run4("cfg_pre_wrap", k, rdy);
      end else begin
        p0 = pat(k - 12, 4);
        p1 = pat(k - 12, 10);
        p2 = pat(k - 12, 1);
        push("cfg_new_div", {p0[1], p2[1], p1[1], p0[1]}, {p0[0], p2[0], p1[0], p0[0]},
             4'hF, 1'b1, 8'd0, rdy);
      end
    end

    tick();
    push("reset_mid_run", 4'h0, 4'h0, 4'h0, 1'b0, 8'd0, 1'b1);
    resetn = 1'b1;
    for (int n = 1; n <= 17; n++) begin
      tick();
      push("relock", 4'h0, 4'h0, 4'h0, 1'b0, 8'd0, 1'b1);
    end
    for (int n = 0; n < 4; n++) begin
      tick();
      push("release2", 4'h0, 4'h0, 4'((1 << (n + 1)) - 1), 1'b0, 8'd0, 1'b1);
    end
    for (int k = 0; k <= 8; k++) begin
      tick();
      push_run4("run_after_reset", k, 1'b1);
    end

    // Lock loss in RUN: two synchronizer edges of normal output, then all cleared.
    pll_lock = 1'b0;
    tick();
    push_run4("loss_lag", 9, 1'b1);
    tick();
    push_run4("loss_lag", 10, 1'b1);
    tick();
    push("lock_lost", 4'h0, 4'h0, 4'h0, 1'b0, 8'd1, 1'b1);

    // Each iteration reaches RELEASE and loses lock there: one more loss per pass.
    for (int it = 2; it <= 300; it++) begin
      pll_lock = 1'b1;
      repeat (18) tick();
      pll_lock = 1'b0;
      repeat (5) tick();
      if (it == 2 || it == 254 || it == 255 || it == 256 || it == 300) begin
        push("loss_sat", 4'h0, 4'h0, 4'h0, 1'b0, 8'((it > 255) ? 255 : it), 1'b1);
      end
    end

    repeat (3) tick();
    if (exp_q.size() != 0) begin
      miss_cnt++;
      $display("FAIL end: %0d expectations left unchecked", exp_q.size());
    end
    if (lock_loss_cnt !== 8'd255) begin
      miss_cnt++;
      $display("FAIL end: lock_loss_cnt=%0d, expected 255", lock_loss_cnt);
    end
    if (vec_cnt < 100) begin
      miss_cnt++;
      $display("FAIL end: only %0d vectors checked", vec_cnt);
    end
    if (miss_cnt != 0) begin
        $display("FAIL: %0d vectors applied, %0d miscompares", vec_cnt, miss_cnt);
    end else begin
        $display("PASS: %0d vectors applied, 0 miscompares", vec_cnt);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
